net_resolve_pipe: RTL and testbench

//  Parametrised multi-driver net resolver with runtime-selectable net type. Models the

---
 rtl/net_resolve_pipe.sv | 113 +++++++++++
 tb/tb_net_resolve_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/net_resolve_pipe.sv
// net_resolve_pipe: registered multi-driver net resolver with runtime-selectable net type
module net_resolve_pipe #(
  parameter int N_DRV = 4,
  parameter int WIDTH = 8,
  parameter int unsigned MODE = 0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  input  logic [N_DRV-1:0]       drv_en,
  input  logic [N_DRV*WIDTH-1:0] drv_val,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_mode,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       net_val,
  output logic [WIDTH-1:0]       net_z,
  output logic [WIDTH-1:0]       net_x,
  output logic                   multi_err,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       conf_cnt,
  output logic [3:0]             cur_mode
);
  logic [WIDTH-1:0] and_v, or_v, conf, wval;
  logic [WIDTH-1:0] val_d, z_d, x_d, store_d;
  logic [WIDTH-1:0] val_q, z_q, x_q, store_q;
  logic             any_en, merr_d;
  logic             vld_q, merr_q, cerr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mode_q, mode_d;
  always_comb begin
    and_v = '1;
    or_v  = '0;
    for (int i = 0; i < N_DRV; i++) begin
      and_v = and_v & (drv_en[i] ? drv_val[i*WIDTH +: WIDTH] : '1);
      or_v  = or_v  | (drv_en[i] ? drv_val[i*WIDTH +: WIDTH] : '0);
    end
  end
  // Drivers agree on a bit exactly when its AND and OR over the enabled set match.
  assign any_en = |drv_en;
  assign conf   = any_en ? (and_v ^ or_v) : '0;
  assign wval   = and_v & ~conf;
  always_comb begin
    val_d  = any_en ? wval : '0;
    z_d    = any_en ? '0 : '1;
    x_d    = conf;
    merr_d = 1'b0;
    case (mode_q)
      4'd2: z_d = '0;
      4'd3: begin
        val_d = any_en ? wval : '1;
        z_d   = '0;
      end
      4'd4: begin
        val_d = any_en ? and_v : '0;
        x_d   = '0;
      end
      4'd5: begin
        val_d = any_en ? or_v : '0;
        x_d   = '0;
      end
      4'd6: if (!any_en) begin
        val_d = store_q;
        z_d   = '0;
      end
      4'd7: merr_d = |(drv_en & (drv_en - N_DRV'(1)));
      4'd8: begin
        val_d  = '0;
        z_d    = '1;
        x_d    = '0;
        merr_d = any_en;
      end
      default: ;
    endcase
  end
  // Charge store keeps its old value on bits in conflict.
  assign store_d = (mode_q == 4'd6 && any_en) ? ((store_q & conf) | wval) : store_q;
  assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign mode_d  = (cfg_wr && cfg_mode <= 4'd8) ? cfg_mode : mode_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      val_q   <= '0;
      z_q     <= '0;
      x_q     <= '0;
      merr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE[3:0];
      store_q <= '0;
    end else begin
      vld_q  <= in_vld;
      merr_q <= in_vld & merr_d;
      cerr_q <= cfg_wr && cfg_mode > 4'd8;
      mode_q <= mode_d;
      if (in_vld) begin
        val_q   <= val_d;
        z_q     <= z_d;
        x_q     <= x_d;
        store_q <= store_d;
        if (|x_d) cnt_q <= cnt_d;
      end
    end
  end
  assign out_vld   = vld_q;
  assign net_val   = val_q;
  assign net_z     = z_q;
  assign net_x     = x_q;
  assign multi_err = merr_q;
  assign cfg_err   = cerr_q;
  assign conf_cnt  = cnt_q;
  assign cur_mode  = mode_q;
endmodule

// File: tb/tb_net_resolve_pipe.sv
// tb_net_resolve_pipe: directed vectors with hand-computed expectations for net_resolve_pipe
module tb_net_resolve_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_vld = 1'b0;
  logic [3:0]  drv_en = '0;
  logic [31:0] drv_val = '0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_mode = '0;
  logic        out_vld, multi_err, cfg_err;
  logic [7:0]  net_val, net_z, net_x;
  logic [3:0]  conf_cnt, cur_mode;
  int          n_chk = 0;
  int          n_fail = 0;

  net_resolve_pipe #(.N_DRV(4), .WIDTH(8), .MODE(0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_vld(in_vld), .drv_en(drv_en), .drv_val(drv_val),
    .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .out_vld(out_vld), .net_val(net_val),
    .net_z(net_z), .net_x(net_x), .multi_err(multi_err), .cfg_err(cfg_err),
    .conf_cnt(conf_cnt), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [3:0] en, input logic [7:0] d0, d1, d2, d3);
    in_vld  = 1'b1;
    drv_en  = en;
    drv_val = {d3, d2, d1, d0};
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] m);
    cfg_wr   = 1'b1;
    cfg_mode = m;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_vld", out_vld, 0);
    chk("rst_val", net_val, 0);
    chk("rst_z", net_z, 0);
    chk("rst_cnt", conf_cnt, 0);
    chk("rst_mode", cur_mode, 0);
    // wire, agreeing drivers
    smp(4'b0011, 8'hA5, 8'hA5, 8'h00, 8'h00);
    chk("agree_vld", out_vld, 1);
    chk("agree_val", net_val, 8'hA5);
    chk("agree_x", net_x, 0);
    chk("agree_z", net_z, 0);
    tick();
    chk("idle_vld", out_vld, 0);
    chk("idle_hold", net_val, 8'hA5);
    // wire, full conflict and counter saturation
    smp(4'b0011, 8'hF0, 8'h0F, 8'h00, 8'h00);
    chk("conf_x", net_x, 8'hFF);
    chk("conf_val", net_val, 0);
    chk("conf_cnt1", conf_cnt, 1);
    for (int i = 0; i < 17; i++) smp(4'b0011, 8'hF0, 8'h0F, 8'h00, 8'h00);
    chk("conf_sat", conf_cnt, 15);
    // wand / wor
    cfg(4'd4);
    chk("mode_wand", cur_mode, 4);
    smp(4'b0111, 8'hF0, 8'h3C, 8'hFF, 8'h00);
    chk("wand_val", net_val, 8'h30);
    chk("wand_x", net_x, 0);
    cfg(4'd5);
    smp(4'b0111, 8'hF0, 8'h3C, 8'hFF, 8'h00);
    chk("wor_val", net_val, 8'hFF);
    smp(4'b0000, 8'hF0, 8'h3C, 8'hFF, 8'h00);
    chk("wor_z", net_z, 8'hFF);
    chk("wor_zval", net_val, 0);
    // trireg charge storage, including partial conflict
    cfg(4'd6);
    smp(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
    chk("trireg_drv", net_val, 8'h5A);
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("trireg_hold", net_val, 8'h5A);
    chk("trireg_z", net_z, 0);
    smp(4'b0011, 8'hFF, 8'h0F, 8'h00, 8'h00);
    chk("trireg_x", net_x, 8'hF0);
    chk("trireg_xval", net_val, 8'h0F);
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("trireg_part", net_val, 8'h5F);
    do_reset();
    chk("rst_mode2", cur_mode, 0);
    cfg(4'd6);
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("trireg_clr", net_val, 0);
    // uwire and none
    cfg(4'd7);
    smp(4'b0110, 8'h00, 8'h33, 8'h33, 8'h00);
    chk("uwire_merr", multi_err, 1);
    chk("uwire_x", net_x, 0);
    chk("uwire_val", net_val, 8'h33);
    tick();
    chk("merr_pulse", multi_err, 0);
    smp(4'b0100, 8'h00, 8'h00, 8'h77, 8'h00);
    chk("uwire_one", multi_err, 0);
    cfg(4'd8);
    smp(4'b0001, 8'h12, 8'h00, 8'h00, 8'h00);
    chk("none_merr", multi_err, 1);
    chk("none_z", net_z, 8'hFF);
    chk("none_val", net_val, 0);
    // illegal config, then same-cycle config and sample
    cfg(4'hC);
    chk("cfg_err", cfg_err, 1);
    chk("cfg_keep", cur_mode, 8);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
    cfg_wr   = 1'b1;
    cfg_mode = 4'd2;
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    cfg_wr   = 1'b0;
    chk("same_cyc_z", net_z, 8'hFF);
    chk("same_cyc_merr", multi_err, 0);
    chk("mode_tri0", cur_mode, 2);
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("tri0_val", net_val, 0);
    chk("tri0_z", net_z, 0);
    cfg(4'd3);
    smp(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("tri1_val", net_val, 8'hFF);
    chk("tri1_z", net_z, 0);
    // reset priority over cfg_wr and a pending sample
    reset    = 1'b1;
    cfg_wr   = 1'b1;
    cfg_mode = 4'd5;
    in_vld   = 1'b1;
    drv_en   = 4'b0011;
    tick();
    reset    = 1'b0;
    cfg_wr   = 1'b0;
    in_vld   = 1'b0;
    tick();
    chk("rst_prio_mode", cur_mode, 0);
    chk("rst_drop_vld", out_vld, 0);
    chk("rst_drop_cnt", conf_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
